// File: rtl/coproc_pkg.sv
// Shared definitions for the AXI Stream coprocessor blocks: FSM state
// encoding and the stream data width.
package coproc_pkg;

   localparam int AXIS_DATA_WIDTH = 32;

   localparam logic [2:0] ST_IDLE_OH   = 3'b001;
   localparam logic [2:0] ST_STREAM_OH = 3'b010;
   localparam logic [2:0] ST_DONE_OH   = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE_OH,
      S_STREAM = ST_STREAM_OH,
      S_DONE   = ST_DONE_OH
   } state_e;

endpackage

// File: rtl/res_stream_out_if.sv
// AXI4-Stream master/slave bundle used by the coprocessor output path.
interface res_stream_out_if;
   import coproc_pkg::*;

   logic                       M_AXIS_TVALID;
   logic                       M_AXIS_TREADY;
   logic [AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA;
   logic                       M_AXIS_TLAST;

   modport master (
      output M_AXIS_TVALID,
      output M_AXIS_TDATA,
      output M_AXIS_TLAST,
      input  M_AXIS_TREADY
   );

   modport slave (
      input  M_AXIS_TVALID,
      input  M_AXIS_TDATA,
      input  M_AXIS_TLAST,
      output M_AXIS_TREADY
   );

endinterface

// File: rtl/res_skid_fifo.sv
// Two-entry synchronous FIFO absorbing the one-cycle RAM read latency
// so the stream can stall without losing or repeating a word.
module res_skid_fifo #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout,
   output logic [1:0]       count
);

   logic [width-1:0] mem_q [0:1];
   logic [width-1:0] mem_d [0:1];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             pop_ok;

   assign pop_ok = pop && (count_q != 2'd0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop_ok})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; an empty FIFO presents zero on dout instead.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
   assign count = count_q;

endmodule

// File: rtl/res_stream_out.sv
// Reads a frame of result words from RES_RAM and streams them out over
// AXI4-Stream, with TLAST on the final beat and a Done pulse afterwards.
module res_stream_out
   import coproc_pkg::*;
#(
   parameter int width                  = 8,
   parameter int RES_depth_bits         = 6,
   parameter int NUMBER_OF_OUTPUT_WORDS = 64
) (
   input  logic                      clk,
   input  logic                      Reset,
   input  logic                      Start,
   output logic                      Done,
   output logic                      RES_read_en,
   output logic [RES_depth_bits-1:0] RES_read_address,
   input  logic [width-1:0]          RES_read_data_out,
   res_stream_out_if.master          m_axis
);

   localparam logic [RES_depth_bits-1:0] LAST_IDX =
      RES_depth_bits'(NUMBER_OF_OUTPUT_WORDS - 1);

   state_e                    state_q, state_d;
   logic [RES_depth_bits-1:0] addr_q, addr_d;
   logic [RES_depth_bits-1:0] beat_q, beat_d;
   logic                      issue_done_q, issue_done_d;
   logic                      inflight_q, inflight_d;

   logic                      read_en;
   logic                      done;
   logic                      tvalid;
   logic                      tlast;
   logic                      pop;
   logic [width-1:0]          fifo_dout;
   logic [1:0]                fifo_count;
   logic [2:0]                occ_after;

   res_skid_fifo #(
      .width (width)
   ) u_fifo (
      .clk   (clk),
      .Reset (Reset),
      .push  (inflight_q),
      .pop   (pop),
      .din   (RES_read_data_out),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign tvalid = (fifo_count != 2'd0);
   assign tlast  = tvalid && (beat_q == LAST_IDX);
   assign pop    = tvalid && m_axis.M_AXIS_TREADY;

   // Words already owed to the buffer after this cycle's pop; the read
   // landing next cycle must still fit, so buffered + in flight stays <= 2.
   assign occ_after = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight_q};

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      beat_d       = beat_q;
      issue_done_d = issue_done_q;
      read_en      = 1'b0;
      done         = 1'b0;
      case (state_q)
         S_IDLE: begin
            addr_d       = '0;
            beat_d       = '0;
            issue_done_d = 1'b0;
            if (Start) state_d = S_STREAM;
         end
         S_STREAM: begin
            if (!issue_done_q && (occ_after < 3'd2)) begin
               read_en = 1'b1;
               if (addr_q == LAST_IDX) issue_done_d = 1'b1;
               else                    addr_d       = addr_q + 1'b1;
            end
            if (pop) begin
               if (tlast) state_d = S_DONE;
               else       beat_d  = beat_q + 1'b1;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      inflight_d = read_en;
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         beat_q       <= '0;
         issue_done_q <= 1'b0;
         inflight_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         beat_q       <= beat_d;
         issue_done_q <= issue_done_d;
         inflight_q   <= inflight_d;
      end
   end

   assign Done                 = done;
   assign RES_read_en          = read_en;
   assign RES_read_address     = addr_q;
   assign m_axis.M_AXIS_TVALID = tvalid;
   assign m_axis.M_AXIS_TLAST  = tlast;
   assign m_axis.M_AXIS_TDATA  = AXIS_DATA_WIDTH'(fifo_dout);

endmodule

// File: tb/tb_res_stream_out.sv
// Bench for res_stream_out: a 64-word instance and a 1-word instance,
// each reading its own behavioural RES_RAM.
module tb_res_stream_out;

   logic       clk;
   logic       rst;
   logic       start;
   logic       tready;
   logic       sel;

   logic       start_a, start_b;
   logic       done_a, done_b;
   logic       rden_a, rden_b;
   logic [5:0] raddr_a, raddr_b;
   logic [7:0] rdata_a, rdata_b;
   logic [7:0] ram_a [0:63];
   logic [7:0] ram_b [0:63];

   res_stream_out_if ifa ();
   res_stream_out_if ifb ();

   res_stream_out #(
      .width (8), .RES_depth_bits (6), .NUMBER_OF_OUTPUT_WORDS (64)
   ) dut_a (
      .clk (clk), .Reset (rst), .Start (start_a), .Done (done_a),
      .RES_read_en (rden_a), .RES_read_address (raddr_a),
      .RES_read_data_out (rdata_a), .m_axis (ifa)
   );

   res_stream_out #(
      .width (8), .RES_depth_bits (6), .NUMBER_OF_OUTPUT_WORDS (1)
   ) dut_b (
      .clk (clk), .Reset (rst), .Start (start_b), .Done (done_b),
      .RES_read_en (rden_b), .RES_read_address (raddr_b),
      .RES_read_data_out (rdata_b), .m_axis (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rden_a) rdata_a <= ram_a[raddr_a];
      if (rden_b) rdata_b <= ram_b[raddr_b];
   end

   assign start_a           = start && !sel;
   assign start_b           = start && sel;
   assign ifa.M_AXIS_TREADY = tready;
   assign ifb.M_AXIS_TREADY = tready;

   logic        tv, tl, done, rden;
   logic [31:0] td;
   logic [5:0]  raddr;
   assign tv    = sel ? ifb.M_AXIS_TVALID : ifa.M_AXIS_TVALID;
   assign tl    = sel ? ifb.M_AXIS_TLAST  : ifa.M_AXIS_TLAST;
   assign td    = sel ? ifb.M_AXIS_TDATA  : ifa.M_AXIS_TDATA;
   assign done  = sel ? done_b  : done_a;
   assign rden  = sel ? rden_b  : rden_a;
   assign raddr = sel ? raddr_b : raddr_a;

   int          ncmp = 0;
   int          nerr = 0;
   int          cyc = 0;
   int          n_cur = 64;
   int          reads_f = 0;
   int          beat_idx = 0;
   int          dones = 0;
   int          start_cyc = 0;
   int          first_rd = -1;
   int          first_tv = -1;
   int          first_hs = -1;
   int          last_hs = -1;
   bit          done_exp = 0;
   bit          prev_stall = 0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input int i);
      return sel ? {24'h0, ram_b[i]} : {24'h0, ram_a[i]};
   endfunction

   // One clock: sample at the falling edge, compare against the frame
   // model, update it, then return 1 time unit after the rising edge.
   task automatic tick();
      logic hs;
      @(negedge clk);
      hs = tv && tready;
      if (!rst) begin
         if (prev_stall) begin
            chk("stall_valid", 32'(tv), 32'(1));
            chk("stall_data", td, prev_data);
            chk("stall_last", 32'(tl), 32'(prev_last));
         end
         chk("done", 32'(done), 32'(done_exp));
         if (rden) begin
            chk("read_addr", 32'(raddr), 32'(reads_f));
            chk("read_in_frame", 32'(reads_f < n_cur), 32'(1));
         end
         if (hs) begin
            chk("tdata", td, exp_word(beat_idx));
            chk("tlast", 32'(tl), 32'(beat_idx == n_cur - 1));
         end
         chk("outstanding", 32'((reads_f - beat_idx) <= 2), 32'(1));
      end
      if (rst) begin
         reads_f    = 0;
         beat_idx   = 0;
         done_exp   = 0;
         prev_stall = 0;
      end else begin
         done_exp = hs && (beat_idx == n_cur - 1);
         if (done) dones++;
         if (rden && first_rd < 0) first_rd = cyc;
         if (tv && first_tv < 0) first_tv = cyc;
         if (rden) reads_f++;
         if (hs) begin
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            beat_idx++;
         end
         prev_stall = tv && !tready;
         prev_data  = td;
         prev_last  = tl;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input int n);
      n_cur     = n;
      reads_f   = 0;
      beat_idx  = 0;
      dones     = 0;
      first_rd  = -1;
      first_tv  = -1;
      first_hs  = -1;
      last_hs   = -1;
      start_cyc = cyc;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic run_to_done(input int budget, input string tag);
      int k;
      k = 0;
      while (dones == 0 && k < budget) begin
         tick();
         k++;
      end
      chk({tag, "_done_seen"}, 32'(dones != 0), 32'(1));
   endtask

   initial begin
      int k;
      rst    = 1'b1;
      start  = 1'b0;
      tready = 1'b0;
      sel    = 1'b0;
      for (int i = 0; i < 64; i++) begin
         ram_a[i] = 8'(i + 3);
         ram_b[i] = 8'h00;
      end
      ram_b[0] = 8'hA5;
      repeat (3) tick();
      chk("rst_tvalid", 32'(tv), 32'(0));
      chk("rst_tdata", td, 32'(0));
      chk("rst_tlast", 32'(tl), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_read_en", 32'(rden), 32'(0));
      chk("rst_read_addr", 32'(raddr), 32'(0));
      rst = 1'b0;
      tick();

      // Full-rate frame
      tready = 1'b1;
      start_frame(64);
      run_to_done(200, "full");
      chk("full_first_read", 32'(first_rd), 32'(start_cyc + 1));
      chk("full_first_valid", 32'(first_tv), 32'(start_cyc + 3));
      chk("full_back_to_back", 32'(last_hs - first_hs), 32'(63));
      chk("full_beats", 32'(beat_idx), 32'(64));
      chk("full_idle_valid", 32'(tv), 32'(0));
      chk("full_idle_read", 32'(rden), 32'(0));
      repeat (2) tick();

      // Random backpressure, random RAM, extra Start pulse mid-frame
      for (int i = 0; i < 64; i++) ram_a[i] = 8'($urandom);
      tready = 1'b1;
      start_frame(64);
      k = 0;
      while (dones == 0 && k < 2000) begin
         tready = 1'($urandom_range(0, 1));
         start  = (k == 30);
         tick();
         k++;
      end
      start = 1'b0;
      chk("rand_done_seen", 32'(dones != 0), 32'(1));
      chk("rand_beats", 32'(beat_idx), 32'(64));
      tready = 1'b1;
      repeat (4) tick();
      chk("rand_single_done", 32'(dones), 32'(1));

      // Ten-cycle stall right after the first valid beat
      for (int i = 0; i < 64; i++) ram_a[i] = 8'(i + 3);
      tready = 1'b0;
      start_frame(64);
      k = 0;
      while (first_tv < 0 && k < 20) begin
         tick();
         k++;
      end
      chk("stall_valid_seen", 32'(first_tv >= 0), 32'(1));
      repeat (9) tick();
      chk("stall_hold_valid", 32'(tv), 32'(1));
      chk("stall_hold_data", td, 32'h3);
      chk("stall_reads", 32'(reads_f <= 2), 32'(1));
      tready = 1'b1;
      k = cyc;
      run_to_done(200, "stall");
      chk("stall_resume", 32'(first_hs), 32'(k));
      chk("stall_no_gap", 32'(last_hs - first_hs), 32'(63));
      chk("stall_beats", 32'(beat_idx), 32'(64));

      // Reset in the middle of a frame
      start_frame(64);
      k = 0;
      while (beat_idx < 20 && k < 100) begin
         tick();
         k++;
      end
      chk("abort_reached", 32'(beat_idx), 32'(20));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_valid", 32'(tv), 32'(0));
      chk("abort_read_en", 32'(rden), 32'(0));
      dones = 0;
      repeat (6) tick();
      chk("abort_no_done", 32'(dones), 32'(0));
      start_frame(64);
      run_to_done(200, "restart");
      chk("restart_beats", 32'(beat_idx), 32'(64));
      repeat (2) tick();

      // Single-word frame
      sel = 1'b1;
      tick();
      start_frame(1);
      run_to_done(50, "one");
      chk("one_beats", 32'(beat_idx), 32'(1));
      chk("one_done_after_last", 32'(cyc - 1), 32'(last_hs + 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
